// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The statistics feature is enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  // Burst counter needs at least one bit even when every grant is one word long.
  function automatic int bc_width(input int maxburst);
    return (maxburst > 1) ? $clog2(maxburst) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after start, wrapping.
// Shared by the idle-arbitration and release paths of fifo_wr_arbiter.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            found,
  output logic [IW-1:0]   pick
);

  always_comb begin
    int          idx;
    logic [IW-1:0] idx_v;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(start) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = IW'(idx);
      if (!found && req[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NREQ requesters.
// Define FIFO_ARB_STATS_EN to add the accepted-word and full-stall counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic [NREQ-1:0]          REQ_I,
  input  logic [NREQ*DATASIZE-1:0] DATA_I,
  output logic [NREQ-1:0]          GNT_O,
  output logic [DATASIZE-1:0]      WDATA_O,
  output logic                     WINC_O,
  input  logic                     WFULL_I
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]        WORDS_O,
  output logic [STAT_W-1:0]        STALL_O
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = bc_width(MAXBURST);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [BW-1:0] bc_q, bc_d;

  logic [IW-1:0] base, start, pick;
  logic          found, req_own, accept, burst_end, release_own;

  // After a release LAST becomes the old owner, so both paths search from base+1.
  always_comb begin
    base        = (state_q == GRANT) ? owner_q : last_q;
    start       = (base == IW'(NREQ - 1)) ? '0 : base + 1'b1;
    req_own     = REQ_I[owner_q];
    burst_end   = (bc_q == BW'(MAXBURST - 1));
    accept      = (state_q == GRANT) & req_own & ~WFULL_I & ~RST_I;
    release_own = (state_q == GRANT) & (~req_own | (~WFULL_I & burst_end));
  end

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req   (REQ_I),
    .start (start),
    .found (found),
    .pick  (pick)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    bc_d    = bc_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = pick;
          bc_d    = '0;
        end
      end
      GRANT: begin
        if (release_own) begin
          last_d = owner_q;
          bc_d   = '0;
          if (found) owner_d = pick;
          else       state_d = IDLE;
        end else if (accept) begin
          bc_d = bc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    GNT_O   = '0;
    WDATA_O = '0;
    if (state_q == GRANT) begin
      GNT_O[owner_q] = 1'b1;
      WDATA_O        = DATA_I[owner_q*DATASIZE +: DATASIZE];
    end
    WINC_O = accept;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bc_q    <= bc_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] words_q, stall_q;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (accept) words_q <= words_q + 1'b1;
      if ((state_q == GRANT) && req_own && WFULL_I && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign WORDS_O = words_q;
  assign STALL_O = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic vs. a grant-level model.
// Counter checks are compiled in when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic             CLK_I = 1'b0;
  logic             RST_I;
  logic [NR-1:0]    REQ_I;
  logic [NR*DW-1:0] DATA_I;
  logic [NR-1:0]    GNT_O;
  logic [DW-1:0]    WDATA_O;
  logic             WINC_O;
  logic             WFULL_I;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]      WORDS_O;
  logic [15:0]      STALL_O;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: current owner (-1 = nobody), last owner, words in this grant.
  int m_owner, m_last, m_cnt, m_words, m_stalls;

  fifo_wr_arbiter #(.DATASIZE(DW), .NREQ(NR), .MAXBURST(MB)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .REQ_I   (REQ_I),
    .DATA_I  (DATA_I),
    .GNT_O   (GNT_O),
    .WDATA_O (WDATA_O),
    .WINC_O  (WINC_O),
    .WFULL_I (WFULL_I)
`ifdef FIFO_ARB_STATS_EN
    ,
    .WORDS_O (WORDS_O),
    .STALL_O (STALL_O)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  task automatic next_cycle();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic do_reset();
    RST_I   = 1'b1;
    REQ_I   = '0;
    WFULL_I = 1'b0;
    DATA_I  = '0;
    next_cycle();
    next_cycle();
    RST_I = 1'b0;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int from);
    for (int i = 0; i < NR; i++) begin
      if (r[(from + i) % NR]) return (from + i) % NR;
    end
    return -1;
  endfunction

  task automatic test_reset();
    RST_I   = 1'b1;
    REQ_I   = 4'b1111;
    WFULL_I = 1'b0;
    DATA_I  = 32'h44_33_22_11;
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      @(negedge CLK_I);
      total++;
      if (GNT_O !== 4'b0000 || WINC_O !== 1'b0 || WDATA_O !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got gnt=%b winc=%b wdata=%h exp gnt=0000 winc=0 wdata=00",
                 j, GNT_O, WINC_O, WDATA_O);
      end
    end
    next_cycle();
    RST_I = 1'b0;
    @(negedge CLK_I);
    total++;
    if (GNT_O !== 4'b0000) begin
      bad++;
      $display("FAIL reset_release_idle got gnt=%b exp=0000", GNT_O);
    end
    next_cycle();
    @(negedge CLK_I);
    total++;
    if (GNT_O !== 4'b0001 || WINC_O !== 1'b1 || WDATA_O !== 8'h11) begin
      bad++;
      $display("FAIL reset_first_grant got gnt=%b winc=%b wdata=%h exp gnt=0001 winc=1 wdata=11",
               GNT_O, WINC_O, WDATA_O);
    end
  endtask

  task automatic test_contention();
    int own;
    do_reset();
    REQ_I  = 4'b1111;
    DATA_I = 32'hA3_A2_A1_A0;
    for (int j = 0; j < 17; j++) begin
      next_cycle();
      @(negedge CLK_I);
      own = (j / MB) % NR;
      total++;
      if (GNT_O !== 4'(1 << own) || WINC_O !== 1'b1 || WDATA_O !== 8'(8'hA0 + own)) begin
        bad++;
        $display("FAIL contention cyc=%0d got gnt=%b winc=%b wdata=%h exp gnt=%b winc=1 wdata=%h",
                 j, GNT_O, WINC_O, WDATA_O, 4'(1 << own), 8'(8'hA0 + own));
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    REQ_I = 4'b0100;
    for (int j = 0; j < 10; j++) begin
      next_cycle();
      DATA_I[2*DW +: DW] = 8'(8'h10 + j);
      @(negedge CLK_I);
      total++;
      if (GNT_O !== 4'b0100 || WINC_O !== 1'b1 || WDATA_O !== 8'(8'h10 + j)) begin
        bad++;
        $display("FAIL single cyc=%0d got gnt=%b winc=%b wdata=%h exp gnt=0100 winc=1 wdata=%h",
                 j, GNT_O, WINC_O, WDATA_O, 8'(8'h10 + j));
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] full_pat, winc_pat;
    logic [3:0] exp_gnt;
    full_pat = 8'b0001_1100;
    winc_pat = 8'b1110_0011;
    do_reset();
    REQ_I  = 4'b1010;
    DATA_I = 32'hD3_00_B1_00;
    for (int j = 0; j < 8; j++) begin
      next_cycle();
      WFULL_I = full_pat[j];
      @(negedge CLK_I);
      exp_gnt = (j == 7) ? 4'b1000 : 4'b0010;
      total++;
      if (GNT_O !== exp_gnt || WINC_O !== winc_pat[j]) begin
        bad++;
        $display("FAIL back_pressure cyc=%0d got gnt=%b winc=%b exp gnt=%b winc=%b",
                 j, GNT_O, WINC_O, exp_gnt, winc_pat[j]);
      end
    end
`ifdef FIFO_ARB_STATS_EN
    total++;
    if (STALL_O !== 16'd3 || WORDS_O !== 16'd4) begin
      bad++;
      $display("FAIL back_pressure_stats got stall=%0d words=%0d exp stall=3 words=4", STALL_O, WORDS_O);
    end
`endif
    WFULL_I = 1'b0;
  endtask

  task automatic test_early_drop();
    do_reset();
    REQ_I  = 4'b1001;
    DATA_I = 32'hD3_00_00_C0;
    next_cycle();
    @(negedge CLK_I);
    total++;
    if (GNT_O !== 4'b0001 || WINC_O !== 1'b1 || WDATA_O !== 8'hC0) begin
      bad++;
      $display("FAIL early_drop_word got gnt=%b winc=%b wdata=%h exp gnt=0001 winc=1 wdata=c0",
               GNT_O, WINC_O, WDATA_O);
    end
    next_cycle();
    REQ_I = 4'b1000;
    @(negedge CLK_I);
    total++;
    if (GNT_O !== 4'b0001 || WINC_O !== 1'b0) begin
      bad++;
      $display("FAIL early_drop_cycle got gnt=%b winc=%b exp gnt=0001 winc=0", GNT_O, WINC_O);
    end
    next_cycle();
    @(negedge CLK_I);
    total++;
    if (GNT_O !== 4'b1000 || WINC_O !== 1'b1 || WDATA_O !== 8'hD3) begin
      bad++;
      $display("FAIL early_drop_next got gnt=%b winc=%b wdata=%h exp gnt=1000 winc=1 wdata=d3",
               GNT_O, WINC_O, WDATA_O);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    REQ_I  = 4'b0100;
    DATA_I = 32'h00_E2_00_E0;
    next_cycle();
    @(negedge CLK_I);
    total++;
    if (GNT_O !== 4'b0100 || WINC_O !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_first got gnt=%b winc=%b exp gnt=0100 winc=1", GNT_O, WINC_O);
    end
    next_cycle();
    RST_I = 1'b1;
    REQ_I = 4'b0101;
    @(negedge CLK_I);
    total++;
    if (WINC_O !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_gated got winc=%b exp=0", WINC_O);
    end
    next_cycle();
    RST_I = 1'b0;
    @(negedge CLK_I);
    total++;
    if (GNT_O !== 4'b0000 || WINC_O !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_idle got gnt=%b winc=%b exp gnt=0000 winc=0", GNT_O, WINC_O);
    end
`ifdef FIFO_ARB_STATS_EN
    total++;
    if (WORDS_O !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid_words got=%0d exp=0", WORDS_O);
    end
`endif
    next_cycle();
    @(negedge CLK_I);
    total++;
    if (GNT_O !== 4'b0001 || WINC_O !== 1'b1 || WDATA_O !== 8'hE0) begin
      bad++;
      $display("FAIL rst_mid_regrant got gnt=%b winc=%b wdata=%h exp gnt=0001 winc=1 wdata=e0",
               GNT_O, WINC_O, WDATA_O);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] exp_gnt;
    logic          exp_winc;
    logic [DW-1:0] exp_wdata;
    int            nxt;
    do_reset();
    m_owner = -1; m_last = NR - 1; m_cnt = 0; m_words = 0; m_stalls = 0;
    for (int j = 0; j < 600; j++) begin
      next_cycle();
      // Advance the model by the cycle that just ended, using the inputs it saw.
      if (m_owner < 0) begin
        nxt = rr_pick(REQ_I, (m_last + 1) % NR);
        if (nxt >= 0) begin
          m_owner = nxt;
          m_cnt   = 0;
        end
      end else begin
        if (REQ_I[m_owner] && !WFULL_I) begin
          m_words++;
          m_cnt++;
        end else if (REQ_I[m_owner] && WFULL_I) begin
          m_stalls++;
        end
        if (!REQ_I[m_owner] || m_cnt == MB) begin
          m_last  = m_owner;
          m_cnt   = 0;
          m_owner = rr_pick(REQ_I, (m_last + 1) % NR);
        end
      end
      for (int i = 0; i < NR; i++) REQ_I[i] = ($urandom_range(9) < 7);
      WFULL_I = ($urandom_range(3) == 0);
      DATA_I  = $urandom;
      @(negedge CLK_I);
      exp_gnt   = (m_owner < 0) ? '0 : NR'(1 << m_owner);
      exp_winc  = (m_owner >= 0) && REQ_I[m_owner] && !WFULL_I;
      exp_wdata = (m_owner < 0) ? '0 : DATA_I[m_owner*DW +: DW];
      total++;
      if (GNT_O !== exp_gnt || WINC_O !== exp_winc || WDATA_O !== exp_wdata) begin
        bad++;
        $display("FAIL random cyc=%0d got gnt=%b winc=%b wdata=%h exp gnt=%b winc=%b wdata=%h",
                 j, GNT_O, WINC_O, WDATA_O, exp_gnt, exp_winc, exp_wdata);
      end
    end
`ifdef FIFO_ARB_STATS_EN
    total++;
    if (WORDS_O !== 16'(m_words) || STALL_O !== 16'(m_stalls)) begin
      bad++;
      $display("FAIL random_stats got words=%0d stall=%0d exp words=%0d stall=%0d",
               WORDS_O, STALL_O, m_words, m_stalls);
    end
`endif
  endtask

  initial begin
    RST_I   = 1'b1;
    REQ_I   = '0;
    WFULL_I = 1'b0;
    DATA_I  = '0;
    test_reset();
    test_contention();
    test_single();
    test_back_pressure();
    test_early_drop();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
